// File: rtl/fb_pkg.sv
// Shared constants, state encoding and clipping helper for the frame-buffer
// write controller and its raster scanner.
package fb_pkg;

    localparam int          W_RES     = 640;
    localparam int          H_RES     = 480;
    localparam int          SIZE      = 16;
    localparam logic [23:0] CLEAR_RGB = 24'hFFFFFF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_PAINT = 2'd2
    } state_t;

    // Last covered coordinate of a span that starts at 'start' and is 'size'
    // wide, clipped to the screen edge. The sum is formed at 12 bits so a
    // start near 2047 cannot wrap around to a small value.
    function automatic logic [10:0] clip_end(input logic [10:0] start,
                                             input int          size,
                                             input int          res);
        logic [11:0] stop_excl;
        stop_excl = {1'b0, start} + 12'(size);
        if (stop_excl > 12'(res)) begin
            clip_end = 11'(res - 1);
        end else begin
            clip_end = 11'(stop_excl - 12'd1);
        end
    endfunction

endpackage

// File: rtl/fb_write_ctrl_if.sv
// Request/acknowledge and pixel-write bus of the frame-buffer write controller.
interface fb_write_ctrl_if;

    logic        clear_req;
    logic        paint_req;
    logic [10:0] paint_x;
    logic [10:0] paint_y;
    logic [23:0] paint_rgb;
    logic        clear_ack;
    logic        paint_ack;
    logic        write_enable;
    logic [10:0] wr_x;
    logic [10:0] wr_y;
    logic [7:0]  wr_r;
    logic [7:0]  wr_g;
    logic [7:0]  wr_b;
    logic        busy;
    logic        done;

    // Requester side.
    modport master (
        output clear_req, paint_req, paint_x, paint_y, paint_rgb,
        input  clear_ack, paint_ack, write_enable, wr_x, wr_y,
               wr_r, wr_g, wr_b, busy, done
    );

    // Controller side.
    modport slave (
        input  clear_req, paint_req, paint_x, paint_y, paint_rgb,
        output clear_ack, paint_ack, write_enable, wr_x, wr_y,
               wr_r, wr_g, wr_b, busy, done
    );

endinterface

// File: rtl/raster_scan.sv
// Loadable x/y raster counter: x runs fastest from x_start to x_end, then
// wraps and y increments. last_o flags the final coordinate of the window.
module raster_scan #(
    parameter int W_RES = fb_pkg::W_RES,
    parameter int H_RES = fb_pkg::H_RES
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_i,
    input  logic [10:0] x0_i,
    input  logic [10:0] y0_i,
    input  logic [10:0] x1_i,
    input  logic [10:0] y1_i,
    input  logic        step_i,
    output logic [10:0] x_o,
    output logic [10:0] y_o,
    output logic        last_o
);

    logic [10:0] x_q;
    logic [10:0] y_q;
    logic [10:0] x_start_q;
    logic [10:0] x_end_q;
    logic [10:0] y_end_q;

    // Reset leaves a full-screen window loaded so the power-on clear can start
    // immediately; otherwise load a new window or advance one pixel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q       <= '0;
            y_q       <= '0;
            x_start_q <= '0;
            x_end_q   <= 11'(W_RES - 1);
            y_end_q   <= 11'(H_RES - 1);
        end else if (load_i) begin
            x_q       <= x0_i;
            y_q       <= y0_i;
            x_start_q <= x0_i;
            x_end_q   <= x1_i;
            y_end_q   <= y1_i;
        end else if (step_i) begin
            if (x_q == x_end_q) begin
                x_q <= x_start_q;
                y_q <= y_q + 11'd1;
            end else begin
                x_q <= x_q + 11'd1;
            end
        end
    end

    assign x_o    = x_q;
    assign y_o    = y_q;
    assign last_o = (x_q == x_end_q) && (y_q == y_end_q);

endmodule

// File: rtl/fb_write_ctrl.sv
// Frame-buffer write controller: full-screen clear and clipped square paint,
// streaming one pixel write per cycle. Starts with a clear out of reset.
module fb_write_ctrl #(
    parameter int          W_RES     = fb_pkg::W_RES,
    parameter int          H_RES     = fb_pkg::H_RES,
    parameter int          SIZE      = fb_pkg::SIZE,
    parameter logic [23:0] CLEAR_RGB = fb_pkg::CLEAR_RGB
) (
    input  logic            CLOCK_50,
    input  logic            reset,
    fb_write_ctrl_if.slave  bus
);
    import fb_pkg::*;

    state_t      state_q;
    logic        busy_q;
    logic        clear_ack_q;
    logic        paint_ack_q;
    logic        done_q;
    logic        we_q;
    logic        empty_q;
    logic [10:0] wr_x_q;
    logic [10:0] wr_y_q;
    logic [23:0] rgb_q;
    logic [23:0] wr_rgb_q;

    logic        accept_clear;
    logic        accept_paint;
    logic        paint_off;
    logic        beat;
    logic        scan_load;
    logic [10:0] scan_x0_d;
    logic [10:0] scan_y0_d;
    logic [10:0] scan_x1_d;
    logic [10:0] scan_y1_d;
    logic [10:0] scan_x;
    logic [10:0] scan_y;
    logic        scan_last;

    assign accept_clear = (state_q == ST_IDLE) && bus.clear_req;
    assign accept_paint = (state_q == ST_IDLE) && bus.paint_req && !bus.clear_req;
    assign paint_off    = ({1'b0, bus.paint_x} >= 12'(W_RES)) ||
                          ({1'b0, bus.paint_y} >= 12'(H_RES));
    // done_q marks the final beat already on the bus: the cycle after it is
    // spent returning to IDLE, so no further beat is issued.
    assign beat         = (state_q != ST_IDLE) && !done_q && !empty_q;
    assign scan_load    = accept_clear || accept_paint;

    // Window for the scanner: whole screen for a clear, clipped square for a paint.
    always_comb begin
        scan_x0_d = '0;
        scan_y0_d = '0;
        scan_x1_d = 11'(W_RES - 1);
        scan_y1_d = 11'(H_RES - 1);
        if (accept_paint) begin
            scan_x0_d = bus.paint_x;
            scan_y0_d = bus.paint_y;
            scan_x1_d = clip_end(bus.paint_x, SIZE, W_RES);
            scan_y1_d = clip_end(bus.paint_y, SIZE, H_RES);
        end
    end

    raster_scan #(
        .W_RES (W_RES),
        .H_RES (H_RES)
    ) u_scan (
        .clk    (CLOCK_50),
        .rst_n  (reset),
        .load_i (scan_load),
        .x0_i   (scan_x0_d),
        .y0_i   (scan_y0_d),
        .x1_i   (scan_x1_d),
        .y1_i   (scan_y1_d),
        .step_i (beat),
        .x_o    (scan_x),
        .y_o    (scan_y),
        .last_o (scan_last)
    );

    // Control FSM with registered acks, write strobe, coordinates and colour.
    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_CLEAR;
            busy_q      <= 1'b1;
            clear_ack_q <= 1'b0;
            paint_ack_q <= 1'b0;
            done_q      <= 1'b0;
            we_q        <= 1'b0;
            empty_q     <= 1'b0;
            wr_x_q      <= '0;
            wr_y_q      <= '0;
            rgb_q       <= CLEAR_RGB;
            wr_rgb_q    <= '0;
        end else begin
            clear_ack_q <= 1'b0;
            paint_ack_q <= 1'b0;
            done_q      <= 1'b0;
            we_q        <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (accept_clear) begin
                        clear_ack_q <= 1'b1;
                        state_q     <= ST_CLEAR;
                        busy_q      <= 1'b1;
                        rgb_q       <= CLEAR_RGB;
                        empty_q     <= 1'b0;
                    end else if (accept_paint) begin
                        paint_ack_q <= 1'b1;
                        state_q     <= ST_PAINT;
                        busy_q      <= 1'b1;
                        rgb_q       <= bus.paint_rgb;
                        empty_q     <= paint_off;
                    end
                end
                ST_CLEAR, ST_PAINT: begin
                    if (done_q) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else if (empty_q) begin
                        done_q <= 1'b1;
                    end else begin
                        we_q     <= 1'b1;
                        wr_x_q   <= scan_x;
                        wr_y_q   <= scan_y;
                        wr_rgb_q <= rgb_q;
                        done_q   <= scan_last;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.clear_ack    = clear_ack_q;
    assign bus.paint_ack    = paint_ack_q;
    assign bus.write_enable = we_q;
    assign bus.wr_x         = wr_x_q;
    assign bus.wr_y         = wr_y_q;
    assign bus.wr_r         = wr_rgb_q[23:16];
    assign bus.wr_g         = wr_rgb_q[15:8];
    assign bus.wr_b         = wr_rgb_q[7:0];
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;

endmodule

// File: tb/tb_fb_write_ctrl.sv
// Scoreboard bench for fb_write_ctrl on a reduced screen: the stimulus side
// pushes the expected event stream, a negedge monitor pops and compares.
module tb_fb_write_ctrl;

    localparam int          TW   = 40;
    localparam int          TH   = 30;
    localparam int          TS   = 16;
    localparam logic [23:0] TCLR = 24'hA5C3F0;

    // Event kinds seen on the bus.
    localparam int EV_CACK = 0;
    localparam int EV_PACK = 1;
    localparam int EV_BEAT = 2;
    localparam int EV_DONE = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fb_write_ctrl_if bus();

    fb_write_ctrl #(
        .W_RES     (TW),
        .H_RES     (TH),
        .SIZE      (TS),
        .CLEAR_RGB (TCLR)
    ) dut (
        .CLOCK_50 (clk),
        .reset    (rst_n),
        .bus      (bus)
    );

    typedef struct {
        int          kind;
        int          gap;   // required cycles since previous event, 0 = any
        int          x;
        int          y;
        logic [23:0] rgb;
        bit          done;
    } ev_t;

    ev_t exp_q[$];
    int  tests = 0;
    int  fails = 0;
    int  cyc = 0;
    int  last_cyc = 0;
    int  beats_seen = 0;
    bit  chk_busy = 1'b0;

    // ---------------- reference model ----------------
    function automatic void push_ev(int kind, int gap, int x, int y, logic [23:0] rgb, bit done);
        ev_t e;
        e.kind = kind; e.gap = gap; e.x = x; e.y = y; e.rgb = rgb; e.done = done;
        exp_q.push_back(e);
    endfunction

    function automatic void model_rect(int x0, int y0, int x1, int y1, logic [23:0] rgb, int first_gap);
        bit first = 1'b1;
        for (int y = y0; y <= y1; y++) begin
            for (int x = x0; x <= x1; x++) begin
                push_ev(EV_BEAT, first ? first_gap : 1, x, y, rgb, (x == x1) && (y == y1));
                first = 1'b0;
            end
        end
    endfunction

    function automatic void model_clear(bit with_ack, int ack_gap);
        if (with_ack) push_ev(EV_CACK, ack_gap, 0, 0, 24'h0, 1'b0);
        model_rect(0, 0, TW - 1, TH - 1, TCLR, with_ack ? 1 : 0);
    endfunction

    function automatic void model_paint(int px, int py, logic [23:0] rgb, int ack_gap);
        int xe, ye;
        push_ev(EV_PACK, ack_gap, 0, 0, 24'h0, 1'b0);
        if (px >= TW || py >= TH) begin
            push_ev(EV_DONE, 1, 0, 0, 24'h0, 1'b1);
        end else begin
            xe = (px + TS > TW) ? TW - 1 : px + TS - 1;
            ye = (py + TS > TH) ? TH - 1 : py + TS - 1;
            model_rect(px, py, xe, ye, rgb, 1);
        end
    endfunction

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        ev_t o;
        ev_t e;
        bit  have;
        bit  bad;
        cyc++;
        if (!rst_n) begin
            chk_busy = 1'b0;
        end else begin
            if (chk_busy) begin
                chk_busy = 1'b0;
                tests++;
                if (bus.busy !== 1'b0) begin
                    fails++;
                    $display("FAIL busy_after_done: busy=%b required 0", bus.busy);
                end
            end
            have = 1'b1;
            o.kind = 0; o.gap = 0; o.x = 0; o.y = 0; o.rgb = 24'h0; o.done = 1'b0;
            if (bus.clear_ack === 1'b1) o.kind = EV_CACK;
            else if (bus.paint_ack === 1'b1) o.kind = EV_PACK;
            else if (bus.write_enable === 1'b1) begin
                o.kind = EV_BEAT;
                o.x    = int'(bus.wr_x);
                o.y    = int'(bus.wr_y);
                o.rgb  = {bus.wr_r, bus.wr_g, bus.wr_b};
                o.done = (bus.done === 1'b1);
            end else if (bus.done === 1'b1) begin
                o.kind = EV_DONE;
                o.done = 1'b1;
            end else have = 1'b0;

            if (have) begin
                tests++;
                o.gap = cyc - last_cyc;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_event: got kind=%0d x=%0d y=%0d rgb=%h done=%0d, none required",
                             o.kind, o.x, o.y, o.rgb, o.done);
                end else begin
                    e = exp_q.pop_front();
                    bad = (o.kind != e.kind) || (e.gap != 0 && o.gap != e.gap);
                    if (e.kind == EV_BEAT)
                        bad = bad || o.x != e.x || o.y != e.y || o.rgb !== e.rgb ||
                              o.done != e.done || bus.busy !== 1'b1;
                    if (bad) begin
                        fails++;
                        $display("FAIL event: got kind=%0d x=%0d y=%0d rgb=%h done=%0d gap=%0d busy=%b, required kind=%0d x=%0d y=%0d rgb=%h done=%0d gap=%0d",
                                 o.kind, o.x, o.y, o.rgb, o.done, o.gap, bus.busy,
                                 e.kind, e.x, e.y, e.rgb, e.done, e.gap);
                    end
                end
                if (o.kind == EV_BEAT) beats_seen++;
                if (o.done) chk_busy = 1'b1;
                last_cyc = cyc;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    task automatic check_reset();
        chk("rst_write_enable", 32'(bus.write_enable), 32'd0);
        chk("rst_clear_ack",    32'(bus.clear_ack),    32'd0);
        chk("rst_paint_ack",    32'(bus.paint_ack),    32'd0);
        chk("rst_done",         32'(bus.done),         32'd0);
        chk("rst_wr_x",         32'(bus.wr_x),         32'd0);
        chk("rst_wr_y",         32'(bus.wr_y),         32'd0);
        chk("rst_wr_rgb",       32'({bus.wr_r, bus.wr_g, bus.wr_b}), 32'd0);
        chk("rst_busy",         32'(bus.busy),         32'd1);
    endtask

    task automatic request(input bit clr, input bit pnt, input int px, input int py, input logic [23:0] rgb);
        int n = 0;
        bit wc = clr;
        bit wp = pnt;
        bus.paint_x   = 11'(px);
        bus.paint_y   = 11'(py);
        bus.paint_rgb = rgb;
        bus.clear_req = clr;
        bus.paint_req = pnt;
        while ((wc || wp) && n < 5000) begin
            @(posedge clk); #1;
            n++;
            if (wc && bus.clear_ack === 1'b1) begin wc = 1'b0; bus.clear_req = 1'b0; end
            if (wp && bus.paint_ack === 1'b1) begin wp = 1'b0; bus.paint_req = 1'b0; end
        end
        if (wc || wp) begin
            tests++; fails++;
            $display("FAIL ack_timeout: got no ack, required clear=%0d paint=%0d", wc, wp);
            bus.clear_req = 1'b0;
            bus.paint_req = 1'b0;
        end
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || bus.busy === 1'b1) && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= budget) begin
            tests++; fails++;
            $display("FAIL idle_timeout: got %0d events pending busy=%b, required 0 and 0",
                     exp_q.size(), bus.busy);
            exp_q.delete();
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int px, py, base, n;
        logic [23:0] rgb;
        bus.clear_req = 1'b0;
        bus.paint_req = 1'b0;
        bus.paint_x   = '0;
        bus.paint_y   = '0;
        bus.paint_rgb = '0;

        // Reset state, then power-on clear with no ack.
        repeat (3) @(posedge clk);
        #1;
        check_reset();
        model_clear(1'b0, 0);
        @(negedge clk); #1;
        rst_n = 1'b1;
        wait_idle(3000);

        // Unclipped, clipped and off-screen squares.
        model_paint(10, 5, 24'h000000, 0);
        request(1'b0, 1'b1, 10, 5, 24'h000000);
        wait_idle(1000);
        model_paint(TW - 10, TH - 10, 24'h00FF00, 0);
        request(1'b0, 1'b1, TW - 10, TH - 10, 24'h00FF00);
        wait_idle(1000);
        model_paint(TW + 20, 10, 24'h0000FF, 0);
        request(1'b0, 1'b1, TW + 20, 10, 24'h0000FF);
        wait_idle(1000);
        model_paint(2040, 3, 24'h123123, 0);
        request(1'b0, 1'b1, 2040, 3, 24'h123123);
        wait_idle(1000);

        // Random squares, some partly or fully off-screen.
        for (int i = 0; i < 10; i++) begin
            px  = int'($urandom_range(0, TW + 5));
            py  = int'($urandom_range(0, TH + 5));
            rgb = 24'($urandom);
            model_paint(px, py, rgb, 0);
            request(1'b0, 1'b1, px, py, rgb);
            wait_idle(1000);
        end

        // A paint request raised and dropped during a clear is ignored.
        model_clear(1'b1, 0);
        request(1'b1, 1'b0, 0, 0, 24'h0);
        bus.paint_x   = 11'd1;
        bus.paint_y   = 11'd1;
        bus.paint_req = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        bus.paint_req = 1'b0;
        wait_idle(3000);

        // Clear and paint together: clear first, held paint acked after it.
        model_clear(1'b1, 0);
        model_paint(3, 4, 24'h112233, 2);
        request(1'b1, 1'b1, 3, 4, 24'h112233);
        wait_idle(3000);

        // Reset in the middle of a paint aborts it and restarts the clear.
        model_paint(5, 5, 24'hCAFE01, 0);
        base = beats_seen;
        request(1'b0, 1'b1, 5, 5, 24'hCAFE01);
        n = 0;
        while (beats_seen < base + 50 && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        chk("beats_before_reset", 32'(beats_seen - base >= 50), 32'd1);
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        check_reset();
        model_clear(1'b0, 0);
        @(negedge clk); #1;
        rst_n = 1'b1;
        wait_idle(3000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fb_write_ctrl.md
FB_WRITE_CTRL -- requirements
Module: fb_write_ctrl

Interface
REQ-001 SHALL have parameter W_RES, default 640, visible width in pixels.
REQ-002 SHALL have parameter H_RES, default 480, visible height in pixels.
REQ-003 SHALL have parameter SIZE, default 16, edge of painted square in pixels.
REQ-004 SHALL have parameter CLEAR_RGB, default 24'hFFFFFF, fill colour for clear.
REQ-005 SHALL have port CLOCK_50  in  1  sole clock, all logic on rising edge.
REQ-006 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-007 SHALL have port clear_req  in  1  full-screen clear request, held until acked.
REQ-008 SHALL have port paint_req  in  1  square paint request, held until acked.
REQ-009 SHALL have port paint_x  in  11  top-left x of square.
REQ-010 SHALL have port paint_y  in  11  top-left y of square.
REQ-011 SHALL have port paint_rgb  in  24  square colour, {R,G,B}.
REQ-012 SHALL have port clear_ack  out  1  one-cycle acceptance pulse.
REQ-013 SHALL have port paint_ack  out  1  one-cycle acceptance pulse.
REQ-014 SHALL have port write_enable  out  1  buffer write strobe, one pixel per cycle.
REQ-015 SHALL have port wr_x  out  11  write x coordinate.
REQ-016 SHALL have port wr_y  out  11  write y coordinate.
REQ-017 SHALL have ports wr_r, wr_g, wr_b  out  8 each  write colour.
REQ-018 SHALL have port busy  out  1  high whenever state is not IDLE.
REQ-019 SHALL have port done  out  1  one-cycle pulse at completion of each operation.

Function
REQ-020 SHALL implement states IDLE, CLEAR, PAINT; all outputs registered.
REQ-021 SHALL sample requests only in IDLE; requests while busy get no ack and are not queued.
REQ-022 SHALL, in IDLE with clear_req=1, pulse clear_ack and enter CLEAR next edge; clear wins over simultaneous paint_req.
REQ-023 SHALL, in IDLE with paint_req=1 and clear_req=0, latch paint_x/y/rgb, pulse paint_ack, enter PAINT.
REQ-024 SHALL issue first write beat the cycle after ack; one beat per cycle, no gaps.
REQ-025 SHALL, in CLEAR, write CLEAR_RGB in raster order (x fastest) from (0,0) to (W_RES-1,H_RES-1): W_RES*H_RES beats.
REQ-026 SHALL, in PAINT, write x in [px, min(px+SIZE-1,W_RES-1)], y in [py, min(py+SIZE-1,H_RES-1)], raster order; exactly SIZE*SIZE beats unclipped.
REQ-027 SHALL compute px+SIZE and py+SIZE at 12 bits so no wrap-around occurs.
REQ-028 SHALL, if px>=W_RES or py>=H_RES, issue zero beats and pulse done one cycle after paint_ack.
REQ-029 SHALL assert done in the same cycle as the final write beat, then return to IDLE next edge.
REQ-030 SHALL hold write_enable=0 and wr_* at last value outside write beats.

Reset
REQ-031 SHALL, while reset=0, force write_enable, clear_ack, paint_ack, done to 0, wr_x/wr_y/wr_r/wr_g/wr_b to 0, counters to 0.
REQ-032 SHALL enter CLEAR (power-on clear) on reset, busy=1; first beat (0,0) on first edge after release.
REQ-033 SHALL abort any operation mid-stream on reset assertion, with no further beats.

Structure
REQ-034 SHALL place W_RES, H_RES, SIZE, CLEAR_RGB and the 2-bit state enum in shared package fb_pkg.
REQ-035 SHALL use one sub-module raster_scan: loadable x/y counter with start, x/y bounds, last flag, reused by CLEAR and PAINT.

Verification
REQ-036 Reset release -> 307200 white beats, first (0,0), last (639,479) with done=1, busy=0 next cycle.
REQ-037 paint_req (100,200,24'h000000) in IDLE -> paint_ack, then 256 beats x100..115 y200..215, done on beat 256.
REQ-038 paint_req (630,470) -> 100 beats (10x10 clipped), last beat (639,479).
REQ-039 clear_req and paint_req together -> clear_ack only, full clear; held paint_req acked the cycle after return to IDLE.
REQ-040 reset asserted at PAINT beat 50 -> write_enable 0 immediately; after release clear restarts at (0,0).
REQ-041 paint_req (700,10) -> paint_ack, zero beats, done one cycle later.
